// File: rtl/hazard_scoreboard.sv
// Per-register scoreboard for an in-order scalar pipeline: tracks pending writes
// from fixed and variable-latency units and raises RAW/WAW decode/fetch stalls.
module hazard_scoreboard #(
    parameter int NUM_REGS    = 32,
    parameter int REG_AW      = 5,
    parameter int LAT_W       = 3,
    parameter int LAT_VAR     = 2**LAT_W - 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   issue_valid,
    input  logic                   kill_d,
    input  logic [REG_AW-1:0]      rs,
    input  logic [REG_AW-1:0]      rt,
    input  logic                   use_rs,
    input  logic                   use_rt,
    input  logic [REG_AW-1:0]      rd,
    input  logic                   we,
    input  logic [LAT_W-1:0]       lat,
    input  logic                   wb_valid,
    input  logic [REG_AW-1:0]      wb_rd,
    output logic                   stall_d,
    output logic                   stall_if,
    output logic                   issue,
    output logic [NUM_REGS-1:0]    busy_vec,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam logic [LAT_W-1:0] LatVar = LAT_W'(LAT_VAR);

    logic [LAT_W-1:0]       cnt_q [NUM_REGS];
    logic [LAT_W-1:0]       cnt_d [NUM_REGS];
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   raw_hazard, waw_hazard;

    assign raw_hazard = (use_rs && rs != '0 && cnt_q[rs] != '0)
                     || (use_rt && rt != '0 && cnt_q[rt] != '0);

    // A younger write must never complete before an older pending one.
    assign waw_hazard = we && rd != '0 && cnt_q[rd] != '0
                     && (cnt_q[rd] == LatVar || lat < cnt_q[rd]);

    assign stall_d      = issue_valid && !kill_d && (raw_hazard || waw_hazard);
    assign stall_if     = stall_d;
    assign issue        = issue_valid && !kill_d && !stall_d;
    assign stall_cycles = stall_cnt_q;

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (r == 0) begin
                cnt_d[r] = '0;
            end else if (issue && we && rd == REG_AW'(r)) begin
                cnt_d[r] = lat;
            end else if (cnt_q[r] == LatVar) begin
                if (wb_valid && wb_rd == REG_AW'(r)) begin
                    cnt_d[r] = '0;
                end
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - LAT_W'(1);
            end
            busy_vec[r] = (cnt_q[r] != '0);
        end
        stall_cnt_d = stall_cnt_q;
        if (stall_d && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use, multiply chain, variable
// latency, WAW ordering, corner cases, async reset and counter saturation.
module tb_hazard_scoreboard;

    logic        clk;
    logic        reset;
    logic        issue_valid;
    logic        kill_d;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        use_rs;
    logic        use_rt;
    logic [4:0]  rd;
    logic        we;
    logic [2:0]  lat;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        stall_d;
    logic        stall_if;
    logic        issue;
    logic [31:0] busy_vec;
    logic [15:0] stall_cycles;

    int n_chk  = 0;
    int n_fail = 0;

    hazard_scoreboard dut (
        .clk          (clk),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .kill_d       (kill_d),
        .rs           (rs),
        .rt           (rt),
        .use_rs       (use_rs),
        .use_rt       (use_rt),
        .rd           (rd),
        .we           (we),
        .lat          (lat),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .stall_d      (stall_d),
        .stall_if     (stall_if),
        .issue        (issue),
        .busy_vec     (busy_vec),
        .stall_cycles (stall_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; kill_d = 0; rs = 0; rt = 0; use_rs = 0; use_rt = 0;
        rd = 0; we = 0; lat = 0; wb_valid = 0; wb_rd = 0;
    endtask

    task automatic wr(input logic [4:0] d, input logic [2:0] l);
        idle();
        issue_valid = 1; we = 1; rd = d; lat = l;
    endtask

    initial begin
        idle();
        reset = 1;
        #2;
        chk("rst_stall_d", stall_d, 0);
        chk("rst_stall_if", stall_if, 0);
        chk("rst_busy", busy_vec, 0);
        chk("rst_cnt", stall_cycles, 0);
        #10 reset = 0;
        tick();

        // Load-use
        wr(5, 1); #1;
        chk("lu_issue0", issue, 1);
        chk("lu_stall0", stall_d, 0);
        tick();
        idle(); issue_valid = 1; use_rs = 1; rs = 5; #1;
        chk("lu_busy1", busy_vec, 32'h20);
        chk("lu_stall1", stall_d, 1);
        chk("lu_stall_if1", stall_if, 1);
        chk("lu_issue1", issue, 0);
        tick();
        chk("lu_busy2", busy_vec, 0);
        chk("lu_stall2", stall_d, 0);
        chk("lu_issue2", issue, 1);
        chk("lu_cnt", stall_cycles, 1);
        tick();

        // Multiply chain: four stall cycles
        wr(7, 4); #1;
        chk("mul_issue", issue, 1);
        tick();
        idle(); issue_valid = 1; use_rt = 1; rt = 7; #1;
        for (int i = 0; i < 4; i++) begin
            chk("mul_stall", stall_d, 1);
            tick();
        end
        chk("mul_release", stall_d, 0);
        chk("mul_issue2", issue, 1);
        chk("mul_cnt", stall_cycles, 5);
        tick();

        // Variable latency, stray writeback to r3 ignored
        wr(9, 7); #1;
        chk("var_issue", issue, 1);
        tick();
        idle(); issue_valid = 1; use_rs = 1; rs = 9;
        for (int i = 0; i < 20; i++) begin
            wb_valid = (i == 10); wb_rd = 3; #1;
            chk("var_stall", stall_d, 1);
            tick();
        end
        wb_valid = 0; #1;
        chk("var_busy", busy_vec, 32'h200);
        wb_valid = 1; wb_rd = 9; #1;
        chk("var_wb_cycle", stall_d, 1);
        tick();
        wb_valid = 0; #1;
        chk("var_release", stall_d, 0);
        chk("var_issue2", issue, 1);
        chk("var_cnt", stall_cycles, 26);
        tick();

        // WAW with shorter second latency: stall until cnt[4] <= 1
        wr(4, 5); tick();
        wr(4, 1); #1;
        for (int i = 0; i < 4; i++) begin
            chk("waw_stall", stall_d, 1);
            tick();
        end
        chk("waw_release", issue, 1);
        tick();
        idle(); #1;
        chk("waw_busy", busy_vec, 32'h10);
        tick();
        chk("waw_done", busy_vec, 0);
        chk("waw_cnt", stall_cycles, 30);

        // WAW with longer second latency issues at once, cnt[4] = 6
        wr(4, 5); tick();
        wr(4, 6); #1;
        chk("waw6_issue", issue, 1);
        tick();
        idle();
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("waw6_busy", busy_vec, 32'h10);
            tick();
        end
        chk("waw6_done", busy_vec, 0);

        // r0 never busy, never stalls
        wr(0, 3); #1;
        chk("r0_issue", issue, 1);
        tick();
        chk("r0_busy", busy_vec, 0);
        wr(0, 3); use_rs = 1; rs = 0; use_rt = 1; rt = 0; #1;
        chk("r0_nostall", stall_d, 0);
        tick();

        // kill_d masks the hazard and the write
        wr(8, 3); tick();
        wr(10, 2); use_rs = 1; rs = 8; kill_d = 1; #1;
        chk("kill_stall", stall_d, 0);
        chk("kill_issue", issue, 0);
        tick();
        idle(); #1;
        chk("kill_busy", busy_vec, 32'h100);
        tick(); tick();
        chk("kill_drain", busy_vec, 0);

        // Same-cycle issue and writeback to r9: issue wins
        wr(9, 7); wb_valid = 1; wb_rd = 9; #1;
        chk("same_issue", issue, 1);
        tick();
        idle(); tick(); tick();
        chk("same_busy", busy_vec, 32'h200);
        wb_valid = 1; wb_rd = 9; tick();
        idle(); #1;
        chk("same_clear", busy_vec, 0);

        // Async reset with r2 variable and r6 counting
        wr(2, 7); tick();
        wr(6, 3); tick();
        idle(); #1;
        chk("pre_rst_busy", busy_vec, 32'h44);
        reset = 1; #1;
        chk("async_busy", busy_vec, 0);
        chk("async_cnt", stall_cycles, 0);
        #1 reset = 0;
        wb_valid = 1; wb_rd = 2; tick();
        idle(); #1;
        chk("post_rst_busy", busy_vec, 0);

        // Saturation of the stall counter
        wr(11, 7); tick();
        idle(); issue_valid = 1; use_rs = 1; rs = 11;
        for (int i = 0; i < 65534; i++) tick();
        chk("sat_fffe", stall_cycles, 16'hFFFE);
        tick();
        chk("sat_ffff", stall_cycles, 16'hFFFF);
        for (int i = 0; i < 5; i++) tick();
        chk("sat_hold", stall_cycles, 16'hFFFF);
        chk("sat_stall", stall_d, 1);
        wb_valid = 1; wb_rd = 11; tick();
        wb_valid = 0; #1;
        chk("sat_release", issue, 1);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
